// File: rtl/cache_arbiter.sv
// Round-robin arbiter serialising I-side fills and D-side fills/write-backs
// from the split L1 caches onto a single physical-memory line port.
module cache_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state_r;
    state_t state_next_s;
    logic   last_grant_r;   // 1'b0 = I side, 1'b1 = D side
    logic   i_req_s;
    logic   d_req_s;
    logic   start_s;
    logic   grant_d_s;

    assign i_req_s = i_read;
    assign d_req_s = d_read | d_write;

    // Next-state and grant decision; contention goes to the side not granted last.
    always_comb begin
        state_next_s = state_r;
        start_s      = 1'b0;
        grant_d_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_req_s && d_req_s) begin
                    start_s   = 1'b1;
                    grant_d_s = ~last_grant_r;
                end else if (d_req_s) begin
                    start_s   = 1'b1;
                    grant_d_s = 1'b1;
                end else if (i_req_s) begin
                    start_s   = 1'b1;
                    grant_d_s = 1'b0;
                end else begin
                    start_s   = 1'b0;
                    grant_d_s = 1'b0;
                end
                if (start_s) begin
                    state_next_s = grant_d_s ? SERVE_D : SERVE_I;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = state_r;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Registered memory-side request, client responses and captured fill data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= {ADDR_WIDTH{1'b0}};
            pmem_wdata   <= {LINE_WIDTH{1'b0}};
            i_rdata      <= {LINE_WIDTH{1'b0}};
            d_rdata      <= {LINE_WIDTH{1'b0}};
            i_resp       <= 1'b0;
            d_resp       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        last_grant_r <= grant_d_s;
                        if (grant_d_s) begin
                            // Simultaneous d_read/d_write is resolved as a write.
                            pmem_write   <= d_write;
                            pmem_read    <= ~d_write;
                            pmem_address <= d_addr;
                            if (d_write) begin
                                pmem_wdata <= d_wdata;
                            end
                        end else begin
                            pmem_write   <= 1'b0;
                            pmem_read    <= 1'b1;
                            pmem_address <= i_addr;
                        end
                    end
                end
                SERVE_I: begin
                    if (pmem_resp) begin
                        i_rdata   <= pmem_rdata;
                        pmem_read <= 1'b0;
                        i_resp    <= 1'b1;
                    end
                end
                SERVE_D: begin
                    if (pmem_resp) begin
                        if (pmem_read) begin
                            d_rdata <= pmem_rdata;
                        end
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                        d_resp     <= 1'b1;
                    end
                end
                DONE: begin
                    i_resp <= 1'b0;
                    d_resp <= 1'b0;
                end
                default: begin
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                    i_resp     <= 1'b0;
                    d_resp     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter: reset, fills, write-back,
// round-robin contention, mid-transaction changes, async reset, illegal request.
module tb_cache_arbiter;

    logic         clk;
    logic         rst_n;
    logic         i_read;
    logic [15:0]  i_addr;
    logic [127:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [15:0]  d_addr;
    logic [127:0] d_wdata;
    logic [127:0] d_rdata;
    logic         d_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [127:0] LINE_DEAD = {4{32'hDEADBEEF}};
    localparam logic [127:0] LINE_R1   = {4{32'h11112222}};
    localparam logic [127:0] LINE_R2   = {4{32'h33334444}};
    localparam logic [127:0] LINE_R3   = {4{32'h55556666}};
    localparam logic [127:0] LINE_R4   = {4{32'h77778888}};
    localparam logic [127:0] LINE_A5   = {16{8'hA5}};
    localparam logic [127:0] LINE_3C   = {16{8'h3C}};
    localparam logic [127:0] LINE_JUNK = {4{32'hCAFEF00D}};

    cache_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_read       (i_read),
        .i_addr       (i_addr),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_addr(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_line(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        i_read     = 1'b0;
        i_addr     = 16'h0000;
        d_read     = 1'b0;
        d_write    = 1'b0;
        d_addr     = 16'h0000;
        d_wdata    = 128'h0;
        pmem_rdata = 128'h0;
        pmem_resp  = 1'b0;
        step();
        step();

        // Reset values
        chk_bit("rst_pmem_read", pmem_read, 1'b0);
        chk_bit("rst_pmem_write", pmem_write, 1'b0);
        chk_addr("rst_pmem_address", pmem_address, 16'h0000);
        chk_line("rst_pmem_wdata", pmem_wdata, 128'h0);
        chk_line("rst_i_rdata", i_rdata, 128'h0);
        chk_line("rst_d_rdata", d_rdata, 128'h0);
        chk_bit("rst_i_resp", i_resp, 1'b0);
        chk_bit("rst_d_resp", d_resp, 1'b0);
        rst_n = 1'b1;
        step();

        // Single I fill, memory answers on the third strobe cycle
        i_read = 1'b1;
        i_addr = 16'h0040;
        step();
        chk_bit("i1_pmem_read", pmem_read, 1'b1);
        chk_bit("i1_pmem_write", pmem_write, 1'b0);
        chk_addr("i1_pmem_address", pmem_address, 16'h0040);
        step();
        chk_bit("i1_wait1_read", pmem_read, 1'b1);
        chk_bit("i1_wait1_resp", i_resp, 1'b0);
        step();
        chk_bit("i1_wait2_read", pmem_read, 1'b1);
        pmem_resp  = 1'b1;
        pmem_rdata = LINE_DEAD;
        step();
        chk_bit("i1_i_resp", i_resp, 1'b1);
        chk_bit("i1_d_resp", d_resp, 1'b0);
        chk_bit("i1_strobe_low", pmem_read, 1'b0);
        chk_line("i1_i_rdata", i_rdata, LINE_DEAD);
        i_read    = 1'b0;
        pmem_resp = 1'b0;
        step();
        chk_bit("i1_i_resp_pulse", i_resp, 1'b0);
        step();
        chk_bit("i1_no_regrant", pmem_read, 1'b0);

        // Contention with both requests held: D, then I, then D again
        i_read = 1'b1;
        i_addr = 16'h0200;
        d_read = 1'b1;
        d_addr = 16'h0100;
        step();
        chk_bit("c1_pmem_read", pmem_read, 1'b1);
        chk_addr("c1_first_is_d", pmem_address, 16'h0100);
        pmem_resp  = 1'b1;
        pmem_rdata = LINE_R1;
        step();
        chk_bit("c1_d_resp", d_resp, 1'b1);
        chk_bit("c1_i_resp", i_resp, 1'b0);
        chk_line("c1_d_rdata", d_rdata, LINE_R1);
        chk_bit("c1_strobe_low", pmem_read, 1'b0);
        pmem_resp = 1'b0;
        step();
        chk_bit("c1_idle_gap", pmem_read, 1'b0);
        chk_bit("c1_d_resp_pulse", d_resp, 1'b0);
        step();
        chk_bit("c2_pmem_read", pmem_read, 1'b1);
        chk_addr("c2_second_is_i", pmem_address, 16'h0200);
        pmem_resp  = 1'b1;
        pmem_rdata = LINE_R2;
        step();
        chk_bit("c2_i_resp", i_resp, 1'b1);
        chk_bit("c2_d_resp", d_resp, 1'b0);
        chk_line("c2_i_rdata", i_rdata, LINE_R2);
        chk_line("c2_d_rdata_kept", d_rdata, LINE_R1);
        pmem_resp = 1'b0;
        step();
        step();
        chk_addr("c3_third_is_d", pmem_address, 16'h0100);
        pmem_resp  = 1'b1;
        pmem_rdata = LINE_R3;
        step();
        chk_bit("c3_d_resp", d_resp, 1'b1);
        chk_line("c3_d_rdata", d_rdata, LINE_R3);
        i_read    = 1'b0;
        d_read    = 1'b0;
        pmem_resp = 1'b0;
        step();

        // D write-back; data and address held until memory answers
        d_write = 1'b1;
        d_addr  = 16'h1230;
        d_wdata = LINE_A5;
        step();
        chk_bit("w_pmem_write", pmem_write, 1'b1);
        chk_bit("w_pmem_read", pmem_read, 1'b0);
        chk_addr("w_pmem_address", pmem_address, 16'h1230);
        chk_line("w_pmem_wdata", pmem_wdata, LINE_A5);
        d_wdata = LINE_3C;
        step();
        chk_line("w_wdata_held", pmem_wdata, LINE_A5);
        chk_bit("w_write_held", pmem_write, 1'b1);
        pmem_resp  = 1'b1;
        pmem_rdata = LINE_JUNK;
        step();
        chk_bit("w_d_resp", d_resp, 1'b1);
        chk_bit("w_strobe_low", pmem_write, 1'b0);
        chk_line("w_d_rdata_unchanged", d_rdata, LINE_R3);
        d_write   = 1'b0;
        pmem_resp = 1'b0;
        step();

        // Address change and request drop during SERVE_D
        d_read = 1'b1;
        d_addr = 16'h2000;
        step();
        chk_addr("m_addr_initial", pmem_address, 16'h2000);
        d_addr = 16'h3000;
        step();
        chk_addr("m_addr_after_change", pmem_address, 16'h2000);
        d_read = 1'b0;
        step();
        chk_addr("m_addr_after_drop", pmem_address, 16'h2000);
        chk_bit("m_read_after_drop", pmem_read, 1'b1);
        pmem_resp  = 1'b1;
        pmem_rdata = LINE_R4;
        step();
        chk_bit("m_d_resp", d_resp, 1'b1);
        chk_line("m_d_rdata", d_rdata, LINE_R4);
        pmem_resp = 1'b0;
        step();
        chk_bit("m_d_resp_pulse", d_resp, 1'b0);
        chk_bit("m_no_regrant", pmem_read, 1'b0);

        // Asynchronous reset while a read is outstanding
        i_read = 1'b1;
        i_addr = 16'h0300;
        step();
        chk_bit("a_read_before", pmem_read, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_bit("a_read_async_drop", pmem_read, 1'b0);
        i_read = 1'b0;
        step();
        chk_bit("a_no_i_resp", i_resp, 1'b0);
        chk_bit("a_no_d_resp", d_resp, 1'b0);
        chk_line("a_i_rdata_cleared", i_rdata, 128'h0);
        rst_n = 1'b1;
        step();
        chk_bit("a_no_i_resp_after", i_resp, 1'b0);
        i_read = 1'b1;
        i_addr = 16'h0400;
        step();
        chk_bit("a2_pmem_read", pmem_read, 1'b1);
        chk_addr("a2_pmem_address", pmem_address, 16'h0400);
        pmem_resp  = 1'b1;
        pmem_rdata = LINE_R2;
        step();
        chk_bit("a2_i_resp", i_resp, 1'b1);
        chk_line("a2_i_rdata", i_rdata, LINE_R2);
        i_read    = 1'b0;
        pmem_resp = 1'b0;
        step();

        // d_read and d_write together resolves to a write
        d_read  = 1'b1;
        d_write = 1'b1;
        d_addr  = 16'h0500;
        d_wdata = LINE_3C;
        step();
        chk_bit("x_pmem_write", pmem_write, 1'b1);
        chk_bit("x_pmem_read", pmem_read, 1'b0);
        chk_line("x_pmem_wdata", pmem_wdata, LINE_3C);
        pmem_resp  = 1'b1;
        pmem_rdata = LINE_JUNK;
        step();
        chk_bit("x_d_resp", d_resp, 1'b1);
        chk_line("x_d_rdata_unchanged", d_rdata, 128'h0);
        d_read    = 1'b0;
        d_write   = 1'b0;
        pmem_resp = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port memory arbiter that sits directly downstream of the split L1 caches. It serialises line-fill and write-back requests from the instruction-side cache and the data-side cache onto the single physical-memory line port. Clients use a level request / one-cycle response handshake. The grant is round-robin, and each transaction is held until memory answers.

## Interface

Parameters:
- ADDR_WIDTH, 16, byte address width (lc3b_word)
- LINE_WIDTH, 128, cache line width in bits

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  system clock, all state on rising edge
  - rst_n  in  1  asynchronous active-low reset
- Instruction-side client:
  - i_read  in  1  I-side line-fill request (level)
  - i_addr  in  ADDR_WIDTH  I-side line address
  - i_rdata  out  LINE_WIDTH  fill data returned to I-side
  - i_resp  out  1  I-side completion pulse
- Data-side client:
  - d_read  in  1  D-side line-fill request (level)
  - d_write  in  1  D-side write-back request (level)
  - d_addr  in  ADDR_WIDTH  D-side line address
  - d_wdata  in  LINE_WIDTH  D-side write-back data
  - d_rdata  out  LINE_WIDTH  fill data returned to D-side
  - d_resp  out  1  D-side completion pulse
- Physical memory:
  - pmem_read  out  1  memory read strobe (level)
  - pmem_write  out  1  memory write strobe (level)
  - pmem_address  out  ADDR_WIDTH  memory line address
  - pmem_wdata  out  LINE_WIDTH  memory write data
  - pmem_rdata  in  LINE_WIDTH  memory read data, valid with pmem_resp
  - pmem_resp  in  1  memory completion, one or more cycles high

## Operation

- FSM states: IDLE, SERVE_I, SERVE_D, DONE. Reset state is IDLE.
- Request flags: i_req = i_read; d_req = d_read | d_write.
- d_read and d_write together is a client error. The arbiter treats it as a write (write wins).
- Grant in IDLE:
  - Only one request pending: grant that side.
  - Both pending: grant the side opposite to last_grant.
  - last_grant is a 1-bit register, reset value I, so the first contended grant goes to D.
  - last_grant updates on every grant.
- On grant, register the operation (read/write), the address and, for a D write, d_wdata into the pmem_* output registers.
  - Client inputs are not re-sampled until IDLE. Address or data changes mid-transaction are ignored.
- SERVE_I / SERVE_D: hold pmem_read or pmem_write and the address/data stable until pmem_resp = 1.
- On the edge where pmem_resp = 1:
  - For a read, capture pmem_rdata into the granted client's rdata register.
  - Clear pmem_read/pmem_write.
  - Move to DONE.
- DONE: assert the granted client's resp for exactly one cycle, then return to IDLE. Other requests are ignored in DONE.
- A client dropping its request mid-transaction does not abort anything. The transaction completes and resp still pulses.
- i_rdata and d_rdata hold their last captured value until overwritten. Writes do not modify them.
- Reset values: all outputs 0, including i_rdata, d_rdata, pmem_address and pmem_wdata.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and pmem strobes drop asynchronously. No resp is issued for the aborted transaction.

## Timing

- All outputs are registered; there is no combinational path from any input to any output.
- Minimum latency, cycle by cycle:
  - cycle 0: request seen in IDLE
  - cycle 1: pmem strobe high
  - earliest pmem_resp: cycle 1
  - cycle 2: client resp high
  - client request to client resp is therefore 2 + W cycles, where W is the number of extra cycles pmem_resp stays low after cycle 1.
- pmem strobe is low in the cycle resp is high (DONE). Memory sees at least one idle cycle between transactions.
- Back-to-back: the earliest next grant is the IDLE cycle following DONE. So the next strobe comes 2 cycles after the previous strobe falls.
- The client must drop its request in the cycle after seeing resp. Otherwise IDLE re-grants it as a new transaction.
- pmem_resp in IDLE or DONE is ignored.

## Test plan

- Reset then single I fill:
  - Stimulus: i_read=1, i_addr=0x0040; memory answers after 3 cycles with 0x…DEADBEEF.
  - Required: pmem_read rises 1 cycle after the request, pmem_address=0x0040.
  - Required: i_resp is a single-cycle pulse, i_rdata=0x…DEADBEEF, d_resp stays 0.
- D write-back:
  - Stimulus: d_write=1, d_addr=0x1230, d_wdata=0xA5 repeated.
  - Required: pmem_write=1 with that address/data held stable until pmem_resp; d_resp pulses; d_rdata unchanged.
- Simultaneous requests from reset:
  - Stimulus: i_read and d_read asserted in the same cycle.
  - Required: D served first, then I starts 2 cycles after D's strobe falls.
  - Required: repeating the contention gives I first (round-robin alternation).
- Mid-transaction changes:
  - Stimulus: change d_addr from 0x2000 to 0x3000, then drop d_read, while in SERVE_D.
  - Required: pmem_address stays 0x2000; d_resp still pulses once.
- Asynchronous reset mid-read:
  - Stimulus: rst_n=0 while pmem_read=1.
  - Required: pmem_read drops without waiting for a clock; no i_resp/d_resp; a subsequent request completes normally.
- Illegal d_read and d_write together:
  - Required: a write transaction is issued with pmem_read=0.
